// File: rtl/reg_writeback_unit.sv
// -----------------------------------------------------------------------------
// reg_writeback_unit
// Drives the write port (Rd/RW/wr) of the 16x16 register file from two result
// sources. ALU results are single-cycle and always take the port when present.
// Load results returned by data memory arrive at variable times, so they are
// buffered in a small FIFO. The FIFO drains whenever the ALU leaves the port
// idle. A pending-load scoreboard tells decode when a source operand is still
// waiting on a load that has not been written back.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   alu_valid  ALU result present this cycle
//   alu_rd     ALU destination register
//   alu_data   ALU result
//   mem_valid  load data returned this cycle
//   mem_rd     load destination register
//   mem_data   load data
//   mem_ready  FIFO can accept a load result (not full)
//   ld_issue   load issued to memory this cycle
//   ld_rd      destination register of the issued load
//   Rs, Rt     decode-stage source operand queries
//   stall      combinational: either source has a pending load
//   Rd, RW, wr registered register-file write port
//   count      FIFO occupancy
// -----------------------------------------------------------------------------
module reg_writeback_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [3:0]    alu_rd,
    input  logic [15:0]   alu_data,
    input  logic          mem_valid,
    input  logic [3:0]    mem_rd,
    input  logic [15:0]   mem_data,
    output logic          mem_ready,
    input  logic          ld_issue,
    input  logic [3:0]    ld_rd,
    input  logic [3:0]    Rs,
    input  logic [3:0]    Rt,
    output logic          stall,
    output logic [3:0]    Rd,
    output logic [15:0]   RW,
    output logic          wr,
    output logic [AW:0]   count
);

    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [3:0]    r_fifo_rd   [DEPTH];
    logic [15:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [15:0]   r_pend;
    logic [3:0]    r_rd;
    logic [15:0]   r_rw;
    logic          r_wr;

    logic          w_push;
    logic          w_pop;
    logic [3:0]    w_head_rd;
    logic [15:0]   w_head_data;
    logic [15:0]   w_set_mask;
    logic [15:0]   w_clr_mask;

    assign w_head_rd   = r_fifo_rd[r_head];
    assign w_head_data = r_fifo_data[r_head];

    assign mem_ready = (r_count != L_FULL);
    assign w_push    = mem_valid && mem_ready;
    // ALU owns the port whenever it has a result; loads only fill idle slots.
    // A load pushed this cycle is not visible to the pop until the next one.
    assign w_pop     = !alu_valid && (r_count != '0);

    // Set is OR-ed in after the clear, so a re-issued load to the register
    // being written back this cycle stays pending.
    assign w_set_mask = ld_issue ? (16'h0001 << ld_rd)     : 16'h0000;
    assign w_clr_mask = w_pop    ? (16'h0001 << w_head_rd) : 16'h0000;

    assign stall = r_pend[Rs] | r_pend[Rt];

    assign Rd    = r_rd;
    assign RW    = r_rw;
    assign wr    = r_wr;
    assign count = r_count;

    // FIFO storage is not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo_rd[r_tail]   <= mem_rd;
            r_fifo_data[r_tail] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_pend  <= 16'h0000;
            r_rd    <= 4'h0;
            r_rw    <= 16'h0000;
            r_wr    <= 1'b0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;

            if (alu_valid) begin
                r_wr <= 1'b1;
                r_rd <= alu_rd;
                r_rw <= alu_data;
            end else if (w_pop) begin
                r_wr <= 1'b1;
                r_rd <= w_head_rd;
                r_rw <= w_head_data;
            end else begin
                r_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
module tb_reg_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic [3:0]  mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        ld_issue;
    logic [3:0]  ld_rd;
    logic [3:0]  Rs;
    logic [3:0]  Rt;
    logic        stall;
    logic [3:0]  Rd;
    logic [15:0] RW;
    logic        wr;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_writeback_unit #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_ready(mem_ready),
        .ld_issue(ld_issue), .ld_rd(ld_rd),
        .Rs(Rs), .Rt(Rt), .stall(stall),
        .Rd(Rd), .RW(RW), .wr(wr), .count(count)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [3:0]  ard;
        logic [15:0] adata;
        logic        mv;
        logic [3:0]  mrd;
        logic [15:0] mdata;
        logic        li;
        logic [3:0]  lrd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic        ewr;
        logic [3:0]  erd;
        logic [15:0] erw;
        logic [2:0]  ecnt;
        logic        erdy;
        logic        est;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; alu_valid = 1'b0; alu_rd = 4'h0; alu_data = 16'h0;
        mem_valid = 1'b0; mem_rd = 4'h0; mem_data = 16'h0;
        ld_issue = 1'b0; ld_rd = 4'h0; Rs = 4'h0; Rt = 4'h0;
    endtask

    task automatic check_all(input string tag, input logic ewr, input logic [3:0] erd,
                             input logic [15:0] erw, input logic [2:0] ecnt,
                             input logic erdy, input logic est);
        check({tag, ".wr"},        {15'h0, wr},        {15'h0, ewr});
        check({tag, ".Rd"},        {12'h0, Rd},        {12'h0, erd});
        check({tag, ".RW"},        RW,                 erw);
        check({tag, ".count"},     {13'h0, count},     {13'h0, ecnt});
        check({tag, ".mem_ready"}, {15'h0, mem_ready}, {15'h0, erdy});
        check({tag, ".stall"},     {15'h0, stall},     {15'h0, est});
    endtask

    initial begin
        //            rst  av ard  adata     mv mrd  mdata     li lrd   rs    rt    | wr Rd    RW        cnt  rdy st
        vecs[0]  = '{1'b1,1'b1,4'hF,16'h1234,1'b1,4'h3,16'hAAAA,1'b1,4'h2,4'h2,4'h3, 1'b0,4'h0,16'h0000,3'd0,1'b1,1'b0};
        vecs[1]  = '{1'b1,1'b1,4'hF,16'h1234,1'b1,4'h3,16'hAAAA,1'b1,4'h2,4'h2,4'h3, 1'b0,4'h0,16'h0000,3'd0,1'b1,1'b0};
        vecs[2]  = '{1'b0,1'b1,4'hF,16'h0450,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h0, 1'b1,4'hF,16'h0450,3'd0,1'b1,1'b0};
        vecs[3]  = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h0, 1'b0,4'hF,16'h0450,3'd0,1'b1,1'b0};
        vecs[4]  = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b1,4'h9,4'h9,4'h0, 1'b0,4'hF,16'h0450,3'd0,1'b1,1'b1};
        vecs[5]  = '{1'b0,1'b0,4'h0,16'h0000,1'b1,4'h9,16'h3347,1'b0,4'h0,4'h9,4'h0, 1'b0,4'hF,16'h0450,3'd1,1'b1,1'b1};
        vecs[6]  = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h9,4'h0, 1'b1,4'h9,16'h3347,3'd0,1'b1,1'b0};
        vecs[7]  = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h9, 1'b0,4'h9,16'h3347,3'd0,1'b1,1'b0};
        vecs[8]  = '{1'b0,1'b1,4'hA,16'h000A,1'b1,4'h1,16'h1111,1'b0,4'h0,4'h0,4'h0, 1'b1,4'hA,16'h000A,3'd1,1'b1,1'b0};
        vecs[9]  = '{1'b0,1'b1,4'hB,16'h000B,1'b1,4'h2,16'h2222,1'b0,4'h0,4'h0,4'h0, 1'b1,4'hB,16'h000B,3'd2,1'b1,1'b0};
        vecs[10] = '{1'b0,1'b1,4'hC,16'h000C,1'b1,4'h3,16'h3333,1'b0,4'h0,4'h0,4'h0, 1'b1,4'hC,16'h000C,3'd3,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b1,4'hD,16'h000D,1'b1,4'h4,16'h4444,1'b0,4'h0,4'h0,4'h0, 1'b1,4'hD,16'h000D,3'd4,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b1,4'hE,16'h000E,1'b1,4'h5,16'h5555,1'b0,4'h0,4'h0,4'h0, 1'b1,4'hE,16'h000E,3'd4,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h0, 1'b1,4'h1,16'h1111,3'd3,1'b1,1'b0};
        vecs[14] = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h0, 1'b1,4'h2,16'h2222,3'd2,1'b1,1'b0};
        vecs[15] = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h0, 1'b1,4'h3,16'h3333,3'd1,1'b1,1'b0};
        vecs[16] = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h0, 1'b1,4'h4,16'h4444,3'd0,1'b1,1'b0};
        vecs[17] = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h0, 1'b0,4'h4,16'h4444,3'd0,1'b1,1'b0};
        vecs[18] = '{1'b0,1'b1,4'h0,16'hBEEF,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h0, 1'b1,4'h0,16'hBEEF,3'd0,1'b1,1'b0};
        vecs[19] = '{1'b0,1'b0,4'h0,16'h0000,1'b1,4'h6,16'h6666,1'b0,4'h0,4'h0,4'h0, 1'b0,4'h0,16'hBEEF,3'd1,1'b1,1'b0};
        vecs[20] = '{1'b0,1'b0,4'h0,16'h0000,1'b1,4'h7,16'h7777,1'b0,4'h0,4'h0,4'h0, 1'b1,4'h6,16'h6666,3'd1,1'b1,1'b0};
        vecs[21] = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h0, 1'b1,4'h7,16'h7777,3'd0,1'b1,1'b0};
        vecs[22] = '{1'b0,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0,4'h0,4'h0,4'h0, 1'b0,4'h7,16'h7777,3'd0,1'b1,1'b0};

        idle_inputs();
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            rst       = vecs[i].rst;
            alu_valid = vecs[i].av;
            alu_rd    = vecs[i].ard;
            alu_data  = vecs[i].adata;
            mem_valid = vecs[i].mv;
            mem_rd    = vecs[i].mrd;
            mem_data  = vecs[i].mdata;
            ld_issue  = vecs[i].li;
            ld_rd     = vecs[i].lrd;
            Rs        = vecs[i].rs;
            Rt        = vecs[i].rt;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].ewr, vecs[i].erd, vecs[i].erw,
                      vecs[i].ecnt, vecs[i].erdy, vecs[i].est);
        end

        // Set/clear collision on r5: head entry rd=5 pops while a new load to r5 issues.
        idle_inputs();
        ld_issue = 1'b1; ld_rd = 4'h5;
        tick();
        idle_inputs();
        mem_valid = 1'b1; mem_rd = 4'h5; mem_data = 16'h5A5A;
        tick();
        idle_inputs();
        ld_issue = 1'b1; ld_rd = 4'h5; Rt = 4'h5;
        tick();
        check_all("collide", 1'b1, 4'h5, 16'h5A5A, 3'd0, 1'b1, 1'b1);
        idle_inputs();
        Rt = 4'h5;
        tick();
        check("collide.hold_stall", {15'h0, stall}, 16'h0001);

        // Mid-operation reset with count=3 and pend=16'h0006.
        idle_inputs();
        rst = 1'b1;
        tick();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 4'h8; alu_data = 16'h0008;
        ld_issue = 1'b1; ld_rd = 4'h1;
        mem_valid = 1'b1; mem_rd = 4'hC; mem_data = 16'hCCCC;
        tick();
        ld_rd = 4'h2; mem_rd = 4'hD; mem_data = 16'hDDDD;
        tick();
        ld_issue = 1'b0; mem_rd = 4'hE; mem_data = 16'hEEEE;
        Rs = 4'h1; Rt = 4'h2;
        tick();
        check_all("pre_rst", 1'b1, 4'h8, 16'h0008, 3'd3, 1'b1, 1'b1);
        Rs = 4'h1; Rt = 4'h1; #1;
        check("pre_rst.stall_r1", {15'h0, stall}, 16'h0001);
        Rs = 4'h2; Rt = 4'h2; #1;
        check("pre_rst.stall_r2", {15'h0, stall}, 16'h0001);
        Rs = 4'h5; Rt = 4'h3; #1;
        check("pre_rst.stall_r5", {15'h0, stall}, 16'h0000);
        rst = 1'b1;
        tick();
        check_all("mid_rst", 1'b0, 4'h0, 16'h0000, 3'd0, 1'b1, 1'b0);
        idle_inputs();
        for (int r = 0; r < 16; r++) begin
            Rs = 4'(r); Rt = 4'(r); #1;
            check($sformatf("mid_rst.pend%0d", r), {15'h0, stall}, 16'h0000);
        end
        Rs = 4'h0; Rt = 4'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all($sformatf("post_rst%0d", k), 1'b0, 4'h0, 16'h0000, 3'd0, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
